// File: rtl/minibyte_pkg.sv
// minibyte_pkg: shared IO map, timer bit positions and prescale limits for the Minibyte responder
package minibyte_pkg;
  localparam int DEF_RAM_BASE = 8'hE0;
  localparam int DEF_IO_BASE  = 8'hF0;
  localparam logic [3:0] OFF_GPIO_OUT = 4'd0;
  localparam logic [3:0] OFF_GPIO_IN  = 4'd1;
  localparam logic [3:0] OFF_TMR_CNT  = 4'd2;
  localparam logic [3:0] OFF_TMR_CMP  = 4'd3;
  localparam logic [3:0] OFF_TMR_CTRL = 4'd4;
  localparam logic [3:0] OFF_TMR_STAT = 4'd5;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_PRE     = 1;
  localparam int CTRL_IRQEN   = 3;
  localparam int CTRL_AUTOCLR = 4;
  localparam int STAT_MATCH   = 0;
  localparam int STAT_OVF     = 1;
  localparam logic [5:0] PRE_LIM_1  = 6'd0;
  localparam logic [5:0] PRE_LIM_4  = 6'd3;
  localparam logic [5:0] PRE_LIM_16 = 6'd15;
  localparam logic [5:0] PRE_LIM_64 = 6'd63;
  function automatic logic [5:0] pre_limit(input logic [1:0] pre);
    return pre == 2'd0 ? PRE_LIM_1 : pre == 2'd1 ? PRE_LIM_4 : pre == 2'd2 ? PRE_LIM_16 : PRE_LIM_64;
  endfunction
endpackage

// File: rtl/minibyte_timer.sv
// minibyte_timer: prescaled 8-bit timer with compare/overflow status and level interrupt
module minibyte_timer
  import minibyte_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] wdata_i,
  input  logic       we_cnt_i,
  input  logic       we_cmp_i,
  input  logic       we_ctrl_i,
  input  logic       we_stat_i,
  output logic [7:0] cnt_o,
  output logic [7:0] cmp_o,
  output logic [7:0] ctrl_o,
  output logic [7:0] stat_o,
  output logic       irq_o
);
  logic [5:0] pre_q, pre_d;
  logic [7:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic [4:0] ctrl_q, ctrl_d;
  logic [1:0] stat_q, stat_d;
  logic       irq_q, irq_d, tick, hit, wrap;
  always_comb begin
    ctrl_d = we_ctrl_i ? wdata_i[4:0] : ctrl_q;
    cmp_d  = we_cmp_i ? wdata_i : cmp_q;
    // a CTRL write that drops EN kills the tick landing on the same edge
    tick   = ctrl_q[CTRL_EN] && pre_q == pre_limit(ctrl_q[CTRL_PRE +: 2]) && !(we_ctrl_i && !wdata_i[CTRL_EN]);
    hit    = tick && !we_cnt_i && cnt_q == cmp_q;
    wrap   = tick && !we_cnt_i && !(hit && ctrl_q[CTRL_AUTOCLR]) && cnt_q == 8'hFF;
    pre_d  = (we_ctrl_i || tick) ? 6'd0 : ctrl_q[CTRL_EN] ? pre_q + 6'd1 : pre_q;
    cnt_d  = we_cnt_i ? wdata_i : !tick ? cnt_q : (hit && ctrl_q[CTRL_AUTOCLR]) ? 8'h00 : cnt_q + 8'd1;
    stat_d = (stat_q & ~(we_stat_i ? wdata_i[1:0] : 2'b00)) | {wrap, hit};
    irq_d  = ctrl_d[CTRL_IRQEN] && |stat_d;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pre_q  <= '0;
      cnt_q  <= 8'h00;
      cmp_q  <= 8'hFF;
      ctrl_q <= '0;
      stat_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      ctrl_q <= ctrl_d;
      stat_q <= stat_d;
      irq_q  <= irq_d;
    end
  end
  assign cnt_o  = cnt_q;
  assign cmp_o  = cmp_q;
  assign ctrl_o = {3'b000, ctrl_q};
  assign stat_o = {6'b000000, stat_q};
  assign irq_o  = irq_q;
endmodule

// File: rtl/minibyte_memio.sv
// minibyte_memio: Minibyte bus responder decoding ROM window, internal RAM and GPIO/timer IO page
module minibyte_memio
  import minibyte_pkg::*;
#(
  parameter int RAM_DEPTH = 16,
  parameter int RAM_BASE  = DEF_RAM_BASE,
  parameter int IO_BASE   = DEF_IO_BASE
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  input  logic       we_in,
  output logic [7:0] data_out,
  input  logic [7:0] rom_data_in,
  output logic       rom_sel_out,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       irq_out
);
  localparam int AW = $clog2(RAM_DEPTH);
  logic          rom_sel, ram_sel, io_sel, we_io;
  logic [AW-1:0] ram_idx;
  logic [3:0]    io_off;
  logic [7:0]    ram_q [RAM_DEPTH];
  logic [7:0]    gpio_out_q, gpio_out_d, sync1_q, sync2_q, io_rd;
  logic [7:0]    tmr_cnt, tmr_cmp, tmr_ctrl, tmr_stat;
  always_comb begin
    rom_sel    = int'(addr_in) < RAM_BASE;
    ram_sel    = !rom_sel && int'(addr_in) < RAM_BASE + RAM_DEPTH;
    io_sel     = !rom_sel && !ram_sel && int'(addr_in) >= IO_BASE && int'(addr_in) < IO_BASE + 16;
    ram_idx    = AW'(addr_in - 8'(RAM_BASE));
    io_off     = 4'(addr_in - 8'(IO_BASE));
    we_io      = we_in && io_sel;
    gpio_out_d = (we_io && io_off == OFF_GPIO_OUT) ? data_in : gpio_out_q;
    io_rd      = 8'h00;
    case (io_off)
      OFF_GPIO_OUT: io_rd = gpio_out_q;
      OFF_GPIO_IN:  io_rd = sync2_q;
      OFF_TMR_CNT:  io_rd = tmr_cnt;
      OFF_TMR_CMP:  io_rd = tmr_cmp;
      OFF_TMR_CTRL: io_rd = tmr_ctrl;
      OFF_TMR_STAT: io_rd = tmr_stat;
      default:      io_rd = 8'h00;
    endcase
    data_out = rom_sel ? rom_data_in : ram_sel ? ram_q[ram_idx] : io_sel ? io_rd : 8'h00;
  end
  // RAM is deliberately left out of reset
  always_ff @(posedge clk_in) begin
    if (we_in && ram_sel) ram_q[ram_idx] <= data_in;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      gpio_out_q <= 8'h00;
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
    end
  end
  minibyte_timer u_timer (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .wdata_i   (data_in),
    .we_cnt_i  (we_io && io_off == OFF_TMR_CNT),
    .we_cmp_i  (we_io && io_off == OFF_TMR_CMP),
    .we_ctrl_i (we_io && io_off == OFF_TMR_CTRL),
    .we_stat_i (we_io && io_off == OFF_TMR_STAT),
    .cnt_o     (tmr_cnt),
    .cmp_o     (tmr_cmp),
    .ctrl_o    (tmr_ctrl),
    .stat_o    (tmr_stat),
    .irq_o     (irq_out)
  );
  assign rom_sel_out = rom_sel;
  assign gpio_out    = gpio_out_q;
endmodule

// File: tb/tb_minibyte_memio.sv
// tb_minibyte_memio: directed scenario tests for the Minibyte memory/IO responder
module tb_minibyte_memio;
  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [7:0] addr_in = 8'h00, data_in = 8'h00, rom_data_in = 8'h00, gpio_in = 8'h00;
  logic       we_in = 1'b0;
  logic [7:0] data_out, gpio_out;
  logic       rom_sel_out, irq_out;
  int checks = 0;
  int errors = 0;
  minibyte_memio dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .we_in       (we_in),
    .data_out    (data_out),
    .rom_data_in (rom_data_in),
    .rom_sel_out (rom_sel_out),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .irq_out     (irq_out)
  );
  always #10 clk_in = ~clk_in;
  // stimulus changes at the falling edge, so exactly one rising edge separates steps
  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr_in = a;
    data_in = d;
    we_in = 1'b1;
    @(negedge clk_in);
    we_in = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    addr_in = a;
    we_in = 1'b0;
    #1 d = data_out;
  endtask
  task automatic test_reset;
    logic [7:0] d, exp;
    for (int i = 0; i < 16; i++) begin
      rd(8'hF0 + 8'(i), d);
      exp = (i == 3) ? 8'hFF : 8'h00;
      checks++;
      if (d !== exp) begin errors++; $display("FAIL reset_io[%0d] got %h want %h", i, d, exp); end
      step(1);
    end
    checks++;
    if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio_out got %h want 00", gpio_out); end
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq_out); end
    rst_in = 1'b1;
    step(1);
  endtask
  task automatic test_ram;
    logic [7:0] d;
    wr(8'hE3, 8'h5A);
    wr(8'hE4, 8'h0F);
    wr(8'hEF, 8'hC3);
    wr(8'hE0, 8'h11);
    rd(8'hE3, d);
    checks++;
    if (d !== 8'h5A) begin errors++; $display("FAIL ram_e3 got %h want 5a", d); end
    rd(8'hE4, d);
    checks++;
    if (d !== 8'h0F) begin errors++; $display("FAIL ram_e4 got %h want 0f", d); end
    rd(8'hEF, d);
    checks++;
    if (d !== 8'hC3) begin errors++; $display("FAIL ram_ef got %h want c3", d); end
    rd(8'hF0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ram_end_is_io got %h want 00", d); end
    checks++;
    if (rom_sel_out !== 1'b0) begin errors++; $display("FAIL ram_rom_sel got %b want 0", rom_sel_out); end
  endtask
  task automatic test_rom;
    logic [7:0] d;
    rom_data_in = 8'hA5;
    rd(8'h3C, d);
    checks++;
    if (d !== 8'hA5) begin errors++; $display("FAIL rom_read got %h want a5", d); end
    checks++;
    if (rom_sel_out !== 1'b1) begin errors++; $display("FAIL rom_sel got %b want 1", rom_sel_out); end
    rd(8'hDF, d);
    checks++;
    if (rom_sel_out !== 1'b1) begin errors++; $display("FAIL rom_sel_df got %b want 1", rom_sel_out); end
    step(1);
    wr(8'h3C, 8'h77);
    rd(8'hE3, d);
    checks++;
    if (d !== 8'h5A) begin errors++; $display("FAIL rom_wr_ram got %h want 5a", d); end
    rd(8'hF3, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL rom_wr_cmp got %h want ff", d); end
    checks++;
    if (gpio_out !== 8'h00) begin errors++; $display("FAIL rom_wr_gpio got %h want 00", gpio_out); end
  endtask
  task automatic test_gpio;
    logic [7:0] d;
    step(1);
    wr(8'hF0, 8'h81);
    checks++;
    if (gpio_out !== 8'h81) begin errors++; $display("FAIL gpio_out got %h want 81", gpio_out); end
    rd(8'hF0, d);
    checks++;
    if (d !== 8'h81) begin errors++; $display("FAIL gpio_out_rd got %h want 81", d); end
    gpio_in = 8'h3C;
    step(1);
    rd(8'hF1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL gpio_in_edge1 got %h want 00", d); end
    step(1);
    rd(8'hF1, d);
    checks++;
    if (d !== 8'h3C) begin errors++; $display("FAIL gpio_in_edge2 got %h want 3c", d); end
    wr(8'hF9, 8'h55);
    rd(8'hF9, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL io_unused got %h want 00", d); end
  endtask
  task automatic test_timer_match;
    logic [7:0] d;
    wr(8'hF3, 8'h05);
    wr(8'hF4, 8'h1B);
    step(19);
    rd(8'hF2, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL tmr_cnt_e19 got %h want 04", d); end
    step(1);
    rd(8'hF2, d);
    checks++;
    if (d !== 8'h05) begin errors++; $display("FAIL tmr_cnt_e20 got %h want 05", d); end
    rd(8'hF5, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL tmr_stat_e20 got %h want 00", d); end
    step(4);
    rd(8'hF5, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL tmr_match got %h want 01", d); end
    rd(8'hF2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL tmr_autoclr got %h want 00", d); end
    checks++;
    if (irq_out !== 1'b1) begin errors++; $display("FAIL tmr_irq_set got %b want 1", irq_out); end
    wr(8'hF5, 8'h01);
    rd(8'hF5, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL tmr_w1c got %h want 00", d); end
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL tmr_irq_clr got %b want 0", irq_out); end
    wr(8'hF4, 8'hFF);
    rd(8'hF4, d);
    checks++;
    if (d !== 8'h1F) begin errors++; $display("FAIL tmr_ctrl_mask got %h want 1f", d); end
    wr(8'hF4, 8'h00);
  endtask
  task automatic test_overflow;
    logic [7:0] d;
    wr(8'hF3, 8'h00);
    wr(8'hF2, 8'hFE);
    wr(8'hF4, 8'h01);
    rd(8'hF2, d);
    checks++;
    if (d !== 8'hFE) begin errors++; $display("FAIL ovf_load got %h want fe", d); end
    step(1);
    rd(8'hF2, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL ovf_edge1 got %h want ff", d); end
    rd(8'hF5, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ovf_stat_edge1 got %h want 00", d); end
    wr(8'hF5, 8'h02);
    rd(8'hF5, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL ovf_set_wins got %h want 02", d); end
    rd(8'hF2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ovf_wrap got %h want 00", d); end
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL ovf_irq_masked got %b want 0", irq_out); end
    wr(8'hF2, 8'h40);
    rd(8'hF2, d);
    checks++;
    if (d !== 8'h40) begin errors++; $display("FAIL cnt_write_wins got %h want 40", d); end
    rd(8'hF5, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL cnt_write_no_match got %h want 02", d); end
    step(1);
    rd(8'hF2, d);
    checks++;
    if (d !== 8'h41) begin errors++; $display("FAIL cnt_after_load got %h want 41", d); end
    wr(8'hF5, 8'h03);
    rd(8'hF5, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ovf_w1c got %h want 00", d); end
  endtask
  task automatic test_reset_midcount;
    logic [7:0] d;
    rst_in = 1'b0;
    rd(8'hF2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rst_mid_cnt got %h want 00", d); end
    rd(8'hF3, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL rst_mid_cmp got %h want ff", d); end
    checks++;
    if (gpio_out !== 8'h00) begin errors++; $display("FAIL rst_mid_gpio got %h want 00", gpio_out); end
    step(1);
    rst_in = 1'b1;
    step(3);
    rd(8'hF2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rst_restart_disabled got %h want 00", d); end
    rd(8'hF4, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rst_ctrl got %h want 00", d); end
  endtask
  initial begin
    step(2);
    test_reset;
    test_ram;
    test_rom;
    test_gpio;
    test_timer_match;
    test_overflow;
    test_reset_midcount;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/minibyte_memio.md
# minibyte_memio

Memory-and-IO responder for the Minibyte CPU bus: it sits on the far end of the CPU's address/data/write-enable interface and answers every access. It decodes the 8-bit address into an external ROM window, a small internal RAM, and an IO page with GPIO and a programmable timer with interrupt. Reads are combinational, matching the CPU's same-cycle consumption of read data. Writes commit on the rising clock edge.

## Interface
Parameters:
- RAM_DEPTH, 16 — internal RAM bytes; power of two, 2..16.
- RAM_BASE, 8'hE0 — first RAM address; RAM occupies RAM_BASE..RAM_BASE+RAM_DEPTH-1.
- IO_BASE, 8'hF0 — IO page base; the IO page spans IO_BASE..IO_BASE+15.

Ports:
- clk_in  input  1  single clock, all state on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- addr_in  input  8  CPU address.
- data_in  input  8  CPU write data.
- we_in  input  1  write strobe; a write commits at the clock edge while high.
- data_out  output  8  read data to CPU, combinational from addr_in and state.
- rom_data_in  input  8  external ROM data; ROM is addressed directly by addr_in.
- rom_sel_out  output  1  high when addr_in < RAM_BASE.
- gpio_in  input  8  asynchronous input pins.
- gpio_out  output  8  output pin register.
- irq_out  output  1  timer interrupt, level.

## Operation
- Decode: addr < RAM_BASE → ROM. Reads return rom_data_in; writes are ignored. RAM window → RAM. IO page → registers. Any other address reads 8'h00 and ignores writes.
- RAM: plain register array. Not reset; contents are undefined until written. Read is combinational; write is on the edge.
- IO map (offset from IO_BASE):
  - 0 GPIO_OUT: rw, reset 00.
  - 1 GPIO_IN: ro; gpio_in through a 2-flop synchronizer, reset 00.
  - 2 TMR_CNT: rw, reset 00. A write loads the count.
  - 3 TMR_CMP: rw, reset FF.
  - 4 TMR_CTRL: rw, reset 00.
    - bit0 EN.
    - bits2:1 PRE, giving /1, /4, /16, /64.
    - bit3 IRQEN.
    - bit4 AUTOCLR.
    - bits7:5 read 0.
  - 5 TMR_STAT: bit0 MATCH, bit1 OVF. Write-1-to-clear; writing 0 has no effect. Bits7:2 read 0.
  - 6..15: read 00, writes ignored.
- Prescaler:
  - 6-bit counter, runs only while EN=1.
  - A tick fires when the prescaler equals the PRE limit (0, 3, 15, 63); the prescaler then returns to 0.
  - Any write to TMR_CTRL clears the prescaler.
- Timer, on each tick:
  - If CNT==CMP, set MATCH.
  - If CNT==CMP and AUTOCLR=1, CNT←00.
  - Otherwise CNT←CNT+1. A wrap from FF to 00 sets OVF.
- irq_out = IRQEN & (MATCH | OVF). It is driven only from flops, so it is glitch-free.

## Timing
- Reset (rst_in low, async): gpio_out=00, irq_out=0, the synchronizer flops are 00, and the timer registers take their reset values. data_out follows decode during reset.
- Read latency is 0 cycles: data_out is valid in the same cycle as addr_in.
- Write latency is 1 edge: a read of the same address in the next cycle returns the new value.
- gpio_in change → visible in GPIO_IN after 2 edges.
- With PRE=/1, CNT advances every cycle. The first tick after EN is set lands on the edge after the CTRL write.
- Simultaneous events:
  - A CPU write to TMR_CNT in a tick cycle wins over the tick. No MATCH/OVF update occurs from that tick.
  - A W1C of MATCH/OVF in the same cycle as a hardware set: set wins.
  - A TMR_CTRL write clearing EN in a tick cycle: that tick is suppressed.
- rst_in asserted mid-count clears the timer immediately. On deassertion, the timer restarts disabled.

## Structure
- Shared package minibyte_pkg holds:
  - IO offset constants (GPIO_OUT..TMR_STAT).
  - TMR_CTRL/TMR_STAT bit positions.
  - Prescale limit constants.
  - Default RAM_BASE/IO_BASE.
- Sub-module minibyte_timer contains the prescaler, CNT, CMP, CTRL and STAT plus the irq logic. It takes decoded write strobes and returns its register read values.
- The top level holds the decode, RAM, GPIO and the read mux.

## Test plan
- Reset then read every IO offset → 00,00,00,FF,00,00,00…; gpio_out=00, irq_out=0.
- ROM: addr=3C, rom_data_in=A5 → data_out=A5, rom_sel_out=1. A write to 3C leaves RAM and IO unchanged.
- RAM: write 5A to E3, then 0F to E4; read E3 → 5A, E4 → 0F. Address E0+RAM_DEPTH (F0 at default) → hits the IO page, not RAM.
- GPIO: write 81 to F0 → gpio_out=81 after the edge. gpio_in=3C → F1 reads 3C on the 2nd edge, not the 1st.
- Timer:
  - Setup: CMP=05, CTRL=1B (EN, PRE=/4? no: PRE bits=01→/4, IRQEN, AUTOCLR).
  - MATCH sets when CNT reaches 05 after 24 cycles; CNT→00 and irq_out=1.
  - Writing 01 to F5 clears MATCH and drops irq_out.
- Overflow/collisions:
  - Load CNT=FE with /1, EN, AUTOCLR=0, CMP=00 → OVF on the 2nd edge.
  - A W1C issued in the same cycle as the set leaves OVF=1.
  - A CNT write during a tick loads the written value.
